mem_port_arbiter: RTL

- Shares one single-port data RAM (word-addressed, write on posedge, combinational read) between the CPU instruction-fetch port and the load/store data port.
- Sequences each access over a programmable number of wait cycles to model slow memory.
- Returns read data with a one-cycle ready pulse per access.
- Sits between the fetch/MEM stages and the ram instance; the stall logic consumes `i_ready` and `d_ready`.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned WAIT_MAX = 16;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;

  typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_t;

  // Access latched at grant time and replayed to the RAM for the whole access.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select between the fetch and load/store ports.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_INSTR;
    if (i_req && d_req) begin
      // Contention: hand the port to whoever did not get it last time.
      grant_owner = (last_grant == OWN_DATA) ? OWN_INSTR : OWN_DATA;
    end else if (d_req) begin
      grant_owner = OWN_DATA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_INSTR;
    if (d_req) begin
      grant_owner = OWN_DATA;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, holding
// each access for WAIT_CYCLES cycles. Arbitration policy set by MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  arb_owner_t       owner_q, owner_d;
  arb_owner_t       lg_q, lg_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic             we_arm_q, we_arm_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             grant_valid;
  arb_owner_t       grant_owner;

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (lg_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_INSTR;
      lg_q      <= OWN_INSTR;
      cmd_q     <= '0;
      we_arm_q  <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      lg_q      <= lg_d;
      cmd_q     <= cmd_d;
      we_arm_q  <= we_arm_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    lg_d      = lg_q;
    cmd_d     = cmd_q;
    we_arm_d  = 1'b0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          lg_d    = grant_owner;
          cnt_d   = CNT_LOAD;
          state_d = ARB_ACCESS;
          if (grant_owner == OWN_DATA) begin
            cmd_d.addr  = d_addr;
            cmd_d.wdata = d_wdata;
            cmd_d.we    = d_we;
            // Single-cycle access: the first ACCESS cycle is also the last.
            we_arm_d    = d_we && (CNT_LOAD == '0);
          end else begin
            cmd_d.addr  = i_addr;
            cmd_d.we    = 1'b0;
          end
        end
      end

      ARB_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          we_arm_d = cmd_q.we && (cnt_q == CNT_W'(1));
        end else begin
          state_d = ARB_RESP;
          if (owner_q == OWN_DATA) begin
            d_ready_d = 1'b1;
            if (!cmd_q.we) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  // Reset must suppress a write already armed for the final ACCESS cycle.
  assign mem_we    = we_arm_q & ~rst;

endmodule
